sram_access_arbiter: RTL

//  Sequences all accesses to the single external async SRAM (18-bit addr, 8-bit io) and shares it

---
 rtl/sram_access_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares one asynchronous SRAM between a write requester (record path) and a
// read requester (playback path). Generates the cs_n/we_n/oe_n strobes, owns
// the io tristate and always passes through IDLE between transactions, so the
// bus never turns around without a cycle of all strobes high and io released.
module sram_access_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 8,
  parameter int WE_PULSE_CYC = 2,
  parameter int RD_WAIT_CYC  = 2
) (
  input  logic              FPGA_clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_io,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int MAX_CYC = (WE_PULSE_CYC > RD_WAIT_CYC) ? WE_PULSE_CYC : RD_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_LATCH
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_wr;
  logic              grant_rd;
  logic              last_grant_wr;
  logic              io_drive;
  logic [DATA_W-1:0] data_q;

  // The data pins are driven only while a write is in progress.
  assign sram_io = io_drive ? data_q : {DATA_W{1'bz}};

  // Next-state and grant decision; contested requests alternate round-robin.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && rd_req) begin
          grant_rd = last_grant_wr;
          grant_wr = !last_grant_wr;
        end else begin
          grant_wr = wr_req;
          grant_rd = rd_req;
        end
        if (grant_wr) begin
          state_next = WR_SETUP;
        end else if (grant_rd) begin
          state_next = RD_SETUP;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: begin
        if (wait_cnt == CNT_W'(WE_PULSE_CYC - 1)) begin
          state_next = WR_HOLD;
        end
      end
      WR_HOLD:  state_next = IDLE;
      RD_SETUP: state_next = RD_WAIT;
      RD_WAIT: begin
        if (wait_cnt == CNT_W'(RD_WAIT_CYC - 1)) begin
          state_next = RD_LATCH;
        end
      end
      RD_LATCH: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register plus the per-state wait counter, cleared on every state change.
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state_next == state) && ((state == WR_PULSE) || (state == RD_WAIT))) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cs_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      io_drive  <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sram_cs_n <= (state_next == IDLE);
      sram_we_n <= (state_next != WR_PULSE);
      sram_oe_n <= !((state_next == RD_SETUP) || (state_next == RD_WAIT));
      io_drive  <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                   (state_next == WR_HOLD);
      wr_ack    <= (state_next == WR_HOLD);
      rd_valid  <= (state_next == RD_LATCH);
      busy      <= (state_next != IDLE);
    end
  end

  // Address/data capture on grant, round-robin memory, and read data capture.
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr     <= '0;
      data_q        <= '0;
      rd_data       <= '0;
      last_grant_wr <= 1'b1;
    end else begin
      if (grant_wr) begin
        sram_addr     <= wr_addr;
        data_q        <= wr_data;
        last_grant_wr <= 1'b1;
      end else if (grant_rd) begin
        sram_addr     <= rd_addr;
        last_grant_wr <= 1'b0;
      end
      if (state_next == RD_LATCH) begin
        rd_data <= sram_io;
      end
    end
  end

endmodule
